multi_cycle_control: RTL and testbench
======================================

// Module: multi_cycle_control
// PURPOSE
//  Main control FSM and ALU decoder for the multi-cycle MIPS datapath.
//  Sequences the shared memory, ALU, IR/PC and register file (regWrite strobe) over FETCH..WB steps.
//  Moore FSM: outputs are combinational from the registered state; aluControl also depends on funct.
// PARAMETERS
//  OP_RTYPE  6'b000000  R-type opcode
//  OP_LW     6'b100011  load word
//  OP_SW     6'b101011  store word
//  OP_BEQ    6'b000100  branch if equal
//  OP_ADDI   6'b001000  add immediate
//  OP_J      6'b000010  jump
// PORTS
//  clock       in   1  system clock, rising edge
//  reset       in   1  synchronous, active-high
//  opcode      in   6  IR[31:26], stable from DECODE onward
//  funct       in   6  IR[5:0]
//  zero        in   1  ALU zero flag (valid in BRANCH)
//  irWrite     out  1  load IR
//  pcEn        out  1  PC load enable = pcWrite | (branch & zero)
//  iorD        out  1  0: mem addr = PC, 1: mem addr = ALUOut
//  memWrite    out  1  memory write strobe
//  regWrite    out  1  register file write strobe
//  regDst      out  1  0: write reg = rt, 1: write reg = rd
//  memToReg    out  1  0: write data = ALUOut, 1: write data = MDR
//  aluSrcA     out  1  0: PC, 1: A
//  aluSrcB     out  2  00 B, 01 const 4, 10 signImm, 11 signImm<<2
//  pcSrc       out  2  00 ALU result, 01 ALUOut, 10 jump target
//  aluControl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
//  illegalOp   out  1  high in DECODE when opcode matches no parameter
//  instrDone   out  1  high in the final state of every instruction
//  state       out  4  current state encoding (debug)
// BEHAVIOUR
//  Clock and reset: single clock; reset is synchronous, active-high.
//  State encoding: FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 EXEC=6 ALUWB=7 BRANCH=8 ADDIEX=9 ADDIWB=10 JUMP=11.
//  Reset: reset high at a rising edge -> state=FETCH, whatever the current state.
//   Mid-instruction reset abandons the instruction. No regWrite/memWrite strobe occurs after that edge.
//   Outputs after reset = FETCH values.
//  Default: every strobe/select not listed for a state is 0; aluOp defaults to 00.
//   aluOp is an internal 2-bit signal.
//  Per-state outputs and next state:
//   FETCH:  irWrite=1, pcWrite=1, aluSrcB=01, aluOp=00 -> DECODE
//   DECODE: aluSrcB=11, aluOp=00 -> by opcode:
//           LW/SW->MEMADR  RTYPE->EXEC  BEQ->BRANCH  ADDI->ADDIEX  J->JUMP
//           other -> FETCH with illegalOp=1 and instrDone=1 (treated as nop)
//   MEMADR: aluSrcA=1, aluSrcB=10 -> LW:MEMRD, SW:MEMWR
//   MEMRD:  iorD=1 -> MEMWB
//   MEMWB:  memToReg=1, regWrite=1, instrDone=1 -> FETCH
//   MEMWR:  iorD=1, memWrite=1, instrDone=1 -> FETCH
//   EXEC:   aluSrcA=1, aluOp=10 -> ALUWB
//   ALUWB:  regDst=1, regWrite=1, instrDone=1 -> FETCH
//   BRANCH: aluSrcA=1, aluOp=01, pcSrc=01, branch=1, instrDone=1 -> FETCH
//   ADDIEX: aluSrcA=1, aluSrcB=10 -> ADDIWB
//   ADDIWB: regWrite=1, instrDone=1 -> FETCH
//   JUMP:   pcSrc=10, pcWrite=1, instrDone=1 -> FETCH
//   Unused encodings 12-15 -> FETCH with all strobes 0.
//  ALU decode (combinational):
//   aluOp=00 -> 010; aluOp=01 -> 110; aluOp=10 -> decoded from funct:
//   100000->010, 100010->110, 100100->000, 100101->001, 101010->111, other funct->010.
//  pcEn is combinational, same cycle as zero.
//   In BRANCH, pcEn=zero; in FETCH/JUMP, pcEn=1.
//  Latency in cycles, FETCH through last state: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
//   Next FETCH follows immediately.
// TESTING
//  1. reset=1 for 2 edges, release -> state=0, irWrite=1, pcEn=1, aluSrcB=01, aluControl=010, regWrite=0.
//  2. opcode=100011 (lw) -> states 0,1,2,3,4,0. regWrite=1 & memToReg=1 only in state 4. instrDone once.
//  3. opcode=000000, funct=101010 -> EXEC gives aluControl=111. ALUWB gives regWrite=1, regDst=1. 4 cycles total.
//  4. beq with zero=1 -> pcEn=1, pcSrc=01 in BRANCH. With zero=0 -> pcEn=0. Both return to FETCH.
//  5. opcode=111111 -> illegalOp=1 in DECODE, then FETCH. No regWrite/memWrite in the sequence.
//  6. sw: assert reset during MEMADR -> next state FETCH. memWrite never asserted.

Source files
------------

// File: rtl/multi_cycle_control.sv
// Main control FSM and ALU decoder for a multi-cycle MIPS datapath.
// Moore outputs come from the registered state; aluControl also looks at funct.
module multi_cycle_control #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       irWrite,
  output logic       pcEn,
  output logic       iorD,
  output logic       memWrite,
  output logic       regWrite,
  output logic       regDst,
  output logic       memToReg,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] pcSrc,
  output logic [2:0] aluControl,
  output logic       illegalOp,
  output logic       instrDone,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StAddiEx = 4'd9,
    StAddiWb = 4'd10,
    StJump   = 4'd11
  } state_e;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluSlt = 3'b111;

  state_e     state_q, state_d;
  logic       pc_write;
  logic       branch;
  logic [1:0] alu_op;
  logic       op_legal;

  assign op_legal = (opcode == OP_RTYPE) || (opcode == OP_LW)  || (opcode == OP_SW) ||
                    (opcode == OP_BEQ)   || (opcode == OP_ADDI) || (opcode == OP_J);

  // State register: reset wins over any in-flight instruction.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        if (opcode == OP_LW || opcode == OP_SW) begin
          state_d = StMemAdr;
        end else if (opcode == OP_RTYPE) begin
          state_d = StExec;
        end else if (opcode == OP_BEQ) begin
          state_d = StBranch;
        end else if (opcode == OP_ADDI) begin
          state_d = StAddiEx;
        end else if (opcode == OP_J) begin
          state_d = StJump;
        end else begin
          state_d = StFetch;
        end
      end
      StMemAdr: state_d = (opcode == OP_SW) ? StMemWr : StMemRd;
      StMemRd:  state_d = StMemWb;
      StMemWb:  state_d = StFetch;
      StMemWr:  state_d = StFetch;
      StExec:   state_d = StAluWb;
      StAluWb:  state_d = StFetch;
      StBranch: state_d = StFetch;
      StAddiEx: state_d = StAddiWb;
      StAddiWb: state_d = StFetch;
      StJump:   state_d = StFetch;
      default:  state_d = StFetch;
    endcase
  end

  always_comb begin
    irWrite   = 1'b0;
    pc_write  = 1'b0;
    branch    = 1'b0;
    iorD      = 1'b0;
    memWrite  = 1'b0;
    regWrite  = 1'b0;
    regDst    = 1'b0;
    memToReg  = 1'b0;
    aluSrcA   = 1'b0;
    aluSrcB   = 2'b00;
    pcSrc     = 2'b00;
    alu_op    = AluOpAdd;
    illegalOp = 1'b0;
    instrDone = 1'b0;
    case (state_q)
      StFetch: begin
        irWrite  = 1'b1;
        pc_write = 1'b1;
        aluSrcB  = 2'b01;
      end
      StDecode: begin
        aluSrcB   = 2'b11;
        illegalOp = ~op_legal;
        instrDone = ~op_legal;
      end
      StMemAdr: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
      end
      StMemRd: begin
        iorD = 1'b1;
      end
      StMemWb: begin
        memToReg  = 1'b1;
        regWrite  = 1'b1;
        instrDone = 1'b1;
      end
      StMemWr: begin
        iorD      = 1'b1;
        memWrite  = 1'b1;
        instrDone = 1'b1;
      end
      StExec: begin
        aluSrcA = 1'b1;
        alu_op  = AluOpFunct;
      end
      StAluWb: begin
        regDst    = 1'b1;
        regWrite  = 1'b1;
        instrDone = 1'b1;
      end
      StBranch: begin
        aluSrcA   = 1'b1;
        alu_op    = AluOpSub;
        pcSrc     = 2'b01;
        branch    = 1'b1;
        instrDone = 1'b1;
      end
      StAddiEx: begin
        aluSrcA = 1'b1;
        aluSrcB = 2'b10;
      end
      StAddiWb: begin
        regWrite  = 1'b1;
        instrDone = 1'b1;
      end
      StJump: begin
        pcSrc     = 2'b10;
        pc_write  = 1'b1;
        instrDone = 1'b1;
      end
      default: ;
    endcase
  end

  assign pcEn  = pc_write | (branch & zero);
  assign state = state_q;

  // aluOp 11 is never produced; it falls back to add.
  always_comb begin
    aluControl = AluAdd;
    case (alu_op)
      AluOpSub: aluControl = AluSub;
      AluOpFunct: begin
        case (funct)
          6'b100000: aluControl = AluAdd;
          6'b100010: aluControl = AluSub;
          6'b100100: aluControl = AluAnd;
          6'b100101: aluControl = AluOr;
          6'b101010: aluControl = AluSlt;
          default:   aluControl = AluAdd;
        endcase
      end
      default: aluControl = AluAdd;
    endcase
  end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Bench for multi_cycle_control: directed steps plus random instruction stream
// checked each cycle against a per-instruction step list and per-state output table.
module tb_multi_cycle_control;

  logic       clock = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       irWrite, pcEn, iorD, memWrite, regWrite, regDst, memToReg, aluSrcA;
  logic [1:0] aluSrcB, pcSrc;
  logic [2:0] aluControl;
  logic       illegalOp, instrDone;
  logic [3:0] state;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [3:0] st;
    logic       ir, pcen, iord, memw, regw, regdst, m2r, srca;
    logic [1:0] srcb, pcsrc;
    logic [2:0] aluc;
    logic       ill, done;
  } outs_t;

  multi_cycle_control dut (
    .clock      (clock),
    .reset      (reset),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .irWrite    (irWrite),
    .pcEn       (pcEn),
    .iorD       (iorD),
    .memWrite   (memWrite),
    .regWrite   (regWrite),
    .regDst     (regDst),
    .memToReg   (memToReg),
    .aluSrcA    (aluSrcA),
    .aluSrcB    (aluSrcB),
    .pcSrc      (pcSrc),
    .aluControl (aluControl),
    .illegalOp  (illegalOp),
    .instrDone  (instrDone),
    .state      (state)
  );

  always #5 clock = ~clock;

  logic [5:0] legal_ops [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
  logic [5:0] fn_list   [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

  function automatic bit is_legal(input logic [5:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] fn);
    case (fn)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Expected outputs for one step of an instruction, straight from the state table.
  function automatic outs_t model(input int st, input logic [5:0] op, input logic [5:0] fn,
                                  input logic z);
    outs_t o;
    o = '0;
    o.st   = 4'(st);
    o.aluc = 3'b010;
    case (st)
      0:  begin o.ir = 1; o.pcen = 1; o.srcb = 2'b01; end
      1:  begin o.srcb = 2'b11; o.ill = !is_legal(op); o.done = !is_legal(op); end
      2:  begin o.srca = 1; o.srcb = 2'b10; end
      3:  o.iord = 1;
      4:  begin o.m2r = 1; o.regw = 1; o.done = 1; end
      5:  begin o.iord = 1; o.memw = 1; o.done = 1; end
      6:  begin o.srca = 1; o.aluc = funct_alu(fn); end
      7:  begin o.regdst = 1; o.regw = 1; o.done = 1; end
      8:  begin o.srca = 1; o.aluc = 3'b110; o.pcsrc = 2'b01; o.pcen = z; o.done = 1; end
      9:  begin o.srca = 1; o.srcb = 2'b10; end
      10: begin o.regw = 1; o.done = 1; end
      11: begin o.pcsrc = 2'b10; o.pcen = 1; o.done = 1; end
      default: ;
    endcase
    return o;
  endfunction

  function automatic outs_t observed();
    return {state, irWrite, pcEn, iorD, memWrite, regWrite, regDst, memToReg, aluSrcA,
            aluSrcB, pcSrc, aluControl, illegalOp, instrDone};
  endfunction

  int exp_seq[$];
  task automatic build_seq(input logic [5:0] op);
    exp_seq = {0, 1};
    case (op)
      6'b100011: exp_seq = {exp_seq, 2, 3, 4};
      6'b101011: exp_seq = {exp_seq, 2, 5};
      6'b000000: exp_seq = {exp_seq, 6, 7};
      6'b001000: exp_seq = {exp_seq, 9, 10};
      6'b000100: exp_seq = {exp_seq, 8};
      6'b000010: exp_seq = {exp_seq, 11};
      default: ;
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Runs one instruction from FETCH; abort_at >= 0 raises reset during that step.
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input int abort_at, input int zmode);
    int n_done, n_regw, n_memw, e_done, e_regw, e_memw;
    outs_t e, o;
    n_done = 0; n_regw = 0; n_memw = 0; e_done = 0; e_regw = 0; e_memw = 0;
    build_seq(op);
    opcode = op;
    funct  = fn;
    for (int i = 0; i < exp_seq.size(); i++) begin
      zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      if (i == abort_at) reset = 1'b1;
      #1;
      e = model(exp_seq[i], op, fn, zero);
      o = observed();
      chk($sformatf("%s step%0d st%0d", name, i, exp_seq[i]), 32'(o), 32'(e));
      n_done += int'(instrDone); n_regw += int'(regWrite); n_memw += int'(memWrite);
      e_done += int'(e.done);    e_regw += int'(e.regw);    e_memw += int'(e.memw);
      @(posedge clock);
      #1;
      if (i == abort_at) begin
        reset = 1'b0;
        break;
      end
    end
    chk($sformatf("%s done_count", name), 32'(n_done), 32'(e_done));
    chk($sformatf("%s regw_count", name), 32'(n_regw), 32'(e_regw));
    chk($sformatf("%s memw_count", name), 32'(n_memw), 32'(e_memw));
  endtask

  initial begin
    outs_t o;
    logic [5:0] op, fn;
    int abort_at;
    reset = 1'b1; opcode = 6'b0; funct = 6'b0; zero = 1'b0;
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    #1;
    o = observed();
    chk("reset state", 32'(o.st), 32'd0);
    chk("reset irWrite", 32'(o.ir), 32'd1);
    chk("reset pcEn", 32'(o.pcen), 32'd1);
    chk("reset aluSrcB", 32'(o.srcb), 32'd1);
    chk("reset aluControl", 32'(o.aluc), 32'b010);
    chk("reset regWrite", 32'(o.regw), 32'd0);
    #0;

    run_instr("lw", 6'b100011, 6'b000000, -1, -1);
    run_instr("slt", 6'b000000, 6'b101010, -1, -1);
    run_instr("beq_taken", 6'b000100, 6'b000000, -1, 1);
    run_instr("beq_not", 6'b000100, 6'b000000, -1, 0);
    run_instr("illegal", 6'b111111, 6'b000000, -1, -1);
    run_instr("sw_reset", 6'b101011, 6'b000000, 2, -1);
    run_instr("after_rst", 6'b000010, 6'b000000, -1, -1);
    run_instr("j_rst_dec", 6'b000010, 6'b000000, 1, -1);
    run_instr("lw_rst_rd", 6'b100011, 6'b000000, 3, -1);
    run_instr("sw", 6'b101011, 6'b000000, -1, -1);
    run_instr("addi", 6'b001000, 6'b000000, -1, -1);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 6) == 0) begin
        do op = 6'($urandom); while (is_legal(op));
      end else begin
        op = legal_ops[$urandom_range(0, 5)];
      end
      fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fn_list[$urandom_range(0, 4)];
      abort_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr($sformatf("rnd%0d op%0h", n, op), op, fn, abort_at, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
